// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage and its memory.
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: load/store/push/pop over a req/ack memory bus with a 12-bit stack pointer.
// Optional macro STACK_BOUND_CHECK_EN blocks push at SP==0 and pop at SP==SP_INIT and pulses stack_err.
module memory_stage #(
    parameter logic [11:0] SP_INIT = 12'hFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           result_in,
    input  logic [15:0]           read_data1_in,
    input  logic [15:0]           read_data2_in,
    input  logic [31:0]           pc_plus_one_in,
    input  logic [2:0]            flags_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_push,
    input  logic                  mem_pop,
    input  logic [1:0]            memory_address_select,
    input  logic [1:0]            memory_write_src_select,
    input  logic                  reg_write,
    input  logic [2:0]            reg_write_address,
    input  logic [1:0]            wb_sel,
    memory_stage_if.master        dmem,
    output logic                  stall,
    output logic [15:0]           mem_data_out,
    output logic [15:0]           result_out,
    output logic                  reg_write_out,
    output logic [2:0]            reg_write_address_out,
    output logic [1:0]            wb_sel_out,
    output logic [31:0]           popped_pc_out,
    output logic                  pc_load_out,
    output logic [2:0]            popped_flags_out,
    output logic                  flags_load_out,
    output logic [11:0]           sp_out,
    output logic                  stack_err
);
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;
    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_WRITE, OP_READ} op_t;

    state_t      state, state_next;
    op_t         op_sel, op_q;
    logic        any_op, pc_op, pc_q, flag_pop_q, blocked, final_ack;
    logic [11:0] sp, base_addr, first_addr;
    logic [15:0] first_wdata, low_word;

    assign any_op = mem_push | mem_pop | mem_write | mem_read;
    assign sp_out = sp;
    assign dmem.req = (state != IDLE);

    always_comb begin
        if (mem_push)       op_sel = OP_PUSH;
        else if (mem_pop)   op_sel = OP_POP;
        else if (mem_write) op_sel = OP_WRITE;
        else                op_sel = OP_READ;
    end

    // PC as source (push/write) or destination (pop) needs two 16-bit beats
    assign pc_op = (memory_write_src_select == 2'b10) && (op_sel != OP_READ);

`ifdef STACK_BOUND_CHECK_EN
    assign blocked = (state == IDLE) &&
                     ((mem_push && sp == 12'd0) || (op_sel == OP_POP && sp == SP_INIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stack_err <= 1'b0;
        else        stack_err <= blocked;
    end
`else
    assign blocked   = 1'b0;
    assign stack_err = 1'b0;
`endif

    always_comb begin
        case (memory_address_select)
            2'b01:   base_addr = read_data2_in[11:0];
            2'b10:   base_addr = sp;
            default: base_addr = result_in[11:0];
        endcase
        case (op_sel)
            OP_PUSH: first_addr = sp;
            OP_POP:  first_addr = sp + 12'd1;
            default: first_addr = base_addr;
        endcase
        case (memory_write_src_select)
            2'b00:   first_wdata = read_data1_in;
            2'b01:   first_wdata = read_data2_in;
            2'b10:   first_wdata = pc_plus_one_in[31:16];
            default: first_wdata = {13'b0, flags_in};
        endcase
    end

    assign final_ack = dmem.ack && ((state == BEAT1 && !pc_q) || state == BEAT2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (any_op && !blocked) begin
                    state_next = BEAT1;
                    stall      = 1'b1;
                end
            end
            BEAT1: begin
                stall = !final_ack;
                if (dmem.ack) state_next = pc_q ? BEAT2 : IDLE;
            end
            BEAT2: begin
                stall = !final_ack;
                if (dmem.ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are registered so they stay put while the memory inserts wait cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= OP_PUSH;
            pc_q       <= 1'b0;
            flag_pop_q <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= 12'd0;
            dmem.wdata <= 16'd0;
            low_word   <= 16'd0;
            sp         <= SP_INIT;
        end else begin
            if (state == IDLE && state_next == BEAT1) begin
                op_q       <= op_sel;
                pc_q       <= pc_op;
                flag_pop_q <= (op_sel == OP_POP) && (memory_write_src_select == 2'b11);
                dmem.we    <= (op_sel == OP_PUSH) || (op_sel == OP_WRITE);
                dmem.addr  <= first_addr;
                dmem.wdata <= first_wdata;
            end else if (state == BEAT1 && dmem.ack && pc_q) begin
                low_word   <= dmem.rdata;
                dmem.wdata <= pc_plus_one_in[15:0];
                case (op_q)
                    OP_PUSH: dmem.addr <= sp - 12'd1;
                    OP_POP:  dmem.addr <= sp + 12'd2;
                    default: dmem.addr <= dmem.addr + 12'd1;
                endcase
            end
            if (state != IDLE && dmem.ack) begin
                if (op_q == OP_PUSH)     sp <= sp - 12'd1;
                else if (op_q == OP_POP) sp <= sp + 12'd1;
            end
        end
    end

    // MEM/WB register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_data_out          <= 16'd0;
            result_out            <= 16'd0;
            reg_write_out         <= 1'b0;
            reg_write_address_out <= 3'd0;
            wb_sel_out            <= 2'd0;
            popped_pc_out         <= 32'd0;
            pc_load_out           <= 1'b0;
            popped_flags_out      <= 3'd0;
            flags_load_out        <= 1'b0;
        end else begin
            pc_load_out    <= 1'b0;
            flags_load_out <= 1'b0;
            if (stall || blocked) begin
                reg_write_out <= 1'b0;
            end else begin
                result_out            <= result_in;
                reg_write_out         <= reg_write;
                reg_write_address_out <= reg_write_address;
                wb_sel_out            <= wb_sel;
                if (final_ack && (op_q == OP_POP || op_q == OP_READ)) begin
                    mem_data_out <= dmem.rdata;
                    if (op_q == OP_POP && pc_q) begin
                        popped_pc_out <= {dmem.rdata, low_word};
                        pc_load_out   <= 1'b1;
                    end
                    if (flag_pop_q) begin
                        popped_flags_out <= dmem.rdata[2:0];
                        flags_load_out   <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
